// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle for the bit-serial subtractor.
// Handshake: the requester raises start with a and b valid; the block
// accepts them on any rising edge where it is idle or presenting a result
// (state IDLE or DONE). start is ignored while busy. done is a one-cycle
// pulse, and diff/carry/overflow are valid from that cycle until the final
// step of the next operation. state mirrors the controller FSM for
// observation only.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             overflow;
  logic [1:0]       state;

  modport master (
    output start, a, b,
    input  busy, done, diff, carry, overflow, state
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, carry, overflow, state
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial two's-complement subtractor: diff = a - b using one full-adder
// cell stepped LSB first, one bit per clock. The subtrahend is inverted on
// load and the +1 enters as the initial carry, so the cell only ever adds.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_sub_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             cflop;
  logic             c_into_msb;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] diff_q;
  logic             carry_q;
  logic             overflow_q;

  logic             accept;
  logic             last_bit;
  logic             msb_prev_bit;
  logic             fa_sum;
  logic             fa_cout;

  // Single full-adder cell working on the current LSBs.
  assign fa_sum  = sh_a[0] ^ sh_b[0] ^ cflop;
  assign fa_cout = (sh_a[0] & sh_b[0]) | (sh_a[0] & cflop) | (sh_b[0] & cflop);

  // New sum bit enters at the MSB end; after WIDTH steps bit 0 lands at [0].
  assign res_next = (res >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};

  assign last_bit     = (cnt == CW'(WIDTH - 1));
  assign msb_prev_bit = (cnt == CW'(WIDTH - 2));

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; a request is taken in IDLE or DONE, so back-to-back
  // operations run without an idle bubble.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand load on accept, then one serial add step per RUN cycle; the
  // visible result only updates on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a       <= '0;
      sh_b       <= '0;
      res        <= '0;
      cflop      <= 1'b0;
      c_into_msb <= 1'b0;
      cnt        <= '0;
      diff_q     <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      sh_a  <= bus.a;
      sh_b  <= ~bus.b;
      cflop <= 1'b1;
      cnt   <= '0;
      res   <= '0;
    end else if (state == RUN) begin
      res   <= res_next;
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      cflop <= fa_cout;
      cnt   <= cnt + CW'(1);
      if (msb_prev_bit) begin
        c_into_msb <= fa_cout;
      end
      if (last_bit) begin
        diff_q     <= res_next;
        carry_q    <= fa_cout;
        overflow_q <= c_into_msb ^ fa_cout;
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.diff     = diff_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.state    = state;

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial two's-complement subtractor controller. It computes diff = a - b with a single full-adder cell, stepped once per clock, LSB first. An FSM sequences the cell: it loads the operands, inverts b, injects the +1 as the initial carry-in and shifts bits through it. It then presents the result with unsigned carry (no-borrow) and signed overflow flags. It is the area-minimal alternative to the parallel ripple subtractor and sits behind any requester using a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal values 2..32).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only when the FSM is in IDLE or DONE.
a  input  WIDTH  minuend; sampled on the accepting edge only.
b  input  WIDTH  subtrahend; sampled on the accepting edge only.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
diff  output  WIDTH  a - b modulo 2^WIDTH.
carry  output  1  carry out of MSB (1 = no borrow, i.e. a >= b unsigned).
overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (rst_n low, asynchronous): FSM = IDLE; busy, done, carry, overflow = 0; diff = 0; internal shift registers, bit counter and carry flop = 0.
- Reset may assert at any cycle, including mid-RUN: the operation is abandoned and no done is produced. After release the block waits in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start = 1 at edge E0:
  - latch a into shift register A;
  - latch ~b into shift register B;
  - set carry flop = 1 (two's-complement +1);
  - set counter = 0;
  - go to RUN.
  - Otherwise remain in IDLE.
- RUN: each edge E1..E_WIDTH processes one bit:
  - full-adder sum/cout of A[0], B[0], carry flop;
  - shift sum into result register at the MSB end (right shift);
  - shift A and B right by 1;
  - carry flop <= cout;
  - counter += 1.
  - On the edge that processes bit WIDTH-2, save cout as c_into_msb.
- Final RUN edge (counter = WIDTH-1):
  - diff <= completed result, including the final sum bit;
  - carry <= cout;
  - overflow <= c_into_msb XOR cout;
  - go to DONE.
- Latency: done is high in the cycle following E_WIDTH, i.e. WIDTH cycles after the accepting edge.
- busy = 1 exactly in RUN (WIDTH cycles). start is ignored while busy; it is neither queued nor does it disturb the operation.
- DONE: done = 1 for exactly one cycle, busy = 0.
  - If start = 1 at this edge, it is accepted exactly as in IDLE (back-to-back operation, no bubble).
  - Otherwise go to IDLE.
- diff, carry and overflow hold their values until the final RUN edge of the next operation. They do not change on start or in IDLE.
- a and b may change freely after the accepting edge.
- b = 0 yields diff = a, carry = 1, overflow = 0.
- a = b yields diff = 0, carry = 1, overflow = 0.

Test Plan (WIDTH = 8):
- Reset, then start with a=0x05, b=0x03 -> busy high 8 cycles; done pulses once 8 cycles after the accepting edge; diff=0x02, carry=1, overflow=0.
- a=0x03, b=0x05 -> diff=0xFE, carry=0, overflow=0. Then a=0x80, b=0x01 -> diff=0x7F, carry=1, overflow=1.
- a=0x7F, b=0xFF -> diff=0x80, carry=0, overflow=1. Then a=0x5A, b=0x5A -> diff=0x00, carry=1, overflow=0.
- Start held high continuously with operand pairs (0x10,0x01) then (0x01,0x10) -> second operation is accepted in the DONE cycle; results 0x0F/carry 1, then 0xF1/carry 0. Pulses of start during busy do not alter either result.
- Start a=0x20, b=0x01; assert rst_n low at the 4th RUN cycle -> all outputs are 0 immediately (asynchronously). No done appears. A fresh request after release gives the correct result.
- Randomised 1000 operations vs. reference model (a - b, carry = a >= b, signed overflow) -> zero mismatches; done count equals accepted start count.
